aes_key_schedule_iter: RTL and testbench
========================================

AES_KEY_SCHEDULE_ITER -- requirements
Module: aes_key_schedule_iter

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256, meaning the largest key length supported (128, 192 or 256); it sizes the word store to 4*(Nr_max+1) words.
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock; reset is synchronous and active-low.
REQ-003 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port start  input  1  request expansion; accepted only when ready=1.
REQ-005 SHALL have port key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled with start.
REQ-006 SHALL have port key  input  256  cipher key, MSB-aligned (AES-128 uses key[255:128]); sampled with start.
REQ-007 SHALL have port ready  output  1  high in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when expansion completes.
REQ-009 SHALL have port valid  output  1  store holds a complete schedule.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-011 SHALL have port rd_idx  input  4  round-key index 0..Nr.
REQ-012 SHALL have port rd_data  output  128  round key rd_idx, registered, words w[4r]..w[4r+3] MSB-first.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND, DONE; reset enters IDLE.
REQ-014 IDLE + start: if key_len=3 or key length > MAX_KEY_BITS -> pulse err next cycle, remain IDLE, valid unchanged; else latch Nk/Nr (4/10, 6/12, 8/14), write w[0..Nk-1] from key, clear valid, go EXPAND.
REQ-015 EXPAND SHALL generate exactly one word per cycle for i = Nk .. 4*(Nr+1)-1: N = 40/46/52 cycles for 128/192/256.
REQ-016 Word rule: temp=w[i-1]; i mod Nk=0 -> SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}; Nk=8 and i mod 8=4 -> SubWord(temp); w[i]=w[i-Nk] xor temp.
REQ-017 Timing: start sampled at end of cycle 0; words written at end of cycles 1..N; done=1 and valid=1 during cycle N+1 (state DONE); IDLE and ready=1 from cycle N+2.
REQ-018 start while ready=0 SHALL be ignored without err.
REQ-019 rd_data SHALL update one cycle after rd_idx; rd_idx > Nr or valid=0 SHALL return 128'h0.
REQ-020 A new accepted start SHALL overwrite the previous schedule; valid low from cycle 1 until new done.
REQ-021 Rcon SHALL come from a table indexed 1..10 (01,02,04,08,10,20,40,80,1B,36); no runtime GF arithmetic.

Reset
REQ-022 reset_n=0 at a rising edge SHALL force IDLE, ready=1, done=0, valid=0, err=0, rd_data=0, aborting any expansion.
REQ-023 Word store contents need not reset; valid=0 masks stale data.

Configuration
REQ-024 Macro AES_KS_REVERSE_READ_EN defined: add input rd_rev (1 bit); rd_rev=1 returns round key Nr-rd_idx (decryption order), same latency and out-of-range rule.
REQ-025 Macro undefined: rd_rev absent; forward indexing only.

Structure
REQ-026 Shared package aes_pkg SHALL hold the key_len encoding, Nk/Nr constants per mode, the Rcon table, and the S-box table.
REQ-027 Sub-module aes_subword (four parallel S-box lookups, combinational) SHALL be instantiated once.

Verification
REQ-028 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> done in cycle 41; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 gives the key.
REQ-029 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done in cycle 47; rd_idx=12 gives e98ba06f448c773c8ecc720401002202.
REQ-030 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done in cycle 53; rd_idx=14 gives fe4890d1e6188d0b046df344706c631e.
REQ-031 key_len=3, or key_len=2 with MAX_KEY_BITS=128 -> err one cycle, ready stays 1, valid unchanged.
REQ-032 reset_n=0 at cycle 20 of AES-128 run -> cycle after: valid=0, ready=1, rd_data=0; new start completes normally; second start during EXPAND ignored.
REQ-033 With AES_KS_REVERSE_READ_EN, AES-128 vector, rd_rev=1 rd_idx=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=11 -> 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: key length encoding, Nk/Nr per mode,
// Rcon and S-box tables, FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_RSV = 2'd3
  } key_len_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    unique case (kl)
      KL_128:  nk_of = 4'd4;
      KL_192:  nk_of = 4'd6;
      default: nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    unique case (kl)
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  function automatic int key_bits_of(input logic [1:0] kl);
    unique case (kl)
      KL_128:  key_bits_of = 128;
      KL_192:  key_bits_of = 192;
      default: key_bits_of = 256;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    unique case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]],
                 SBOX[din[15:8]],  SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES key expansion, one word per cycle, with round-key read port.
// Optional AES_KS_REVERSE_READ_EN adds rd_rev for decryption-order reads.
module aes_key_schedule_iter
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         ready,
  output logic         done,
  output logic         valid,
  output logic         err,
  input  logic [3:0]   rd_idx,
`ifdef AES_KS_REVERSE_READ_EN
  input  logic         rd_rev,
`endif
  output logic [127:0] rd_data
);

  localparam int NR_MAX = (MAX_KEY_BITS <= 128) ? 10 :
                          (MAX_KEY_BITS <= 192) ? 12 : 14;
  localparam int WORDS  = 4 * (NR_MAX + 1);

  ks_state_t   state;
  logic [31:0] w [WORDS];
  logic [3:0]  nk, nr, rc;
  logic [5:0]  i, last;
  logic [2:0]  pos;

  logic        bad, accept;
  logic [31:0] temp, sub_in, sub_out, f, new_word;

  assign bad    = (key_len == KL_RSV) ||
                  (key_bits_of(key_len) > MAX_KEY_BITS);
  assign accept = (state == IDLE) && start && !bad;

  // pos tracks i mod Nk so no divider is needed
  always_comb begin
    temp   = w[i - 6'd1];
    sub_in = (pos == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    if (pos == 3'd0)
      f = sub_out ^ {rcon(rc), 24'h0};
    else if (nk == 4'd8 && pos == 3'd4)
      f = sub_out;
    else
      f = temp;
    new_word = w[i - {2'b00, nk}] ^ f;
  end

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (accept) begin
        for (int j = 0; j < 8; j++)
          if (j < int'(nk_of(key_len)))
            w[j] <= key[255 - 32*j -: 32];
      end else if (state == EXPAND) begin
        w[i] <= new_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
      nk    <= 4'd4;
      nr    <= 4'd10;
      rc    <= 4'd1;
      i     <= 6'd0;
      last  <= 6'd0;
      pos   <= 3'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && bad) begin
            err <= 1'b1;
          end else if (start) begin
            nk    <= nk_of(key_len);
            nr    <= nr_of(key_len);
            last  <= {nr_of(key_len), 2'b00} + 6'd3;
            i     <= {2'b00, nk_of(key_len)};
            pos   <= 3'd0;
            rc    <= 4'd1;
            valid <= 1'b0;
            ready <= 1'b0;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          i <= i + 6'd1;
          if ({1'b0, pos} == nk - 4'd1) pos <= 3'd0;
          else pos <= pos + 3'd1;
          if (pos == 3'd0) rc <= rc + 4'd1;
          if (i == last) begin
            state <= DONE;
            done  <= 1'b1;
            valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0] r;
  logic [5:0] base;
  logic       in_range;

  always_comb begin
`ifdef AES_KS_REVERSE_READ_EN
    r = rd_rev ? nr - rd_idx : rd_idx;
`else
    r = rd_idx;
`endif
    base     = {r, 2'b00};
    in_range = valid && (rd_idx <= nr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rd_data <= 128'h0;
    else if (in_range)
      rd_data <= {w[base], w[base + 6'd1],
                  w[base + 6'd2], w[base + 6'd3]};
    else
      rd_data <= 128'h0;
  end

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Directed bench for aes_key_schedule_iter using FIPS-197 vectors.
// Define AES_KS_REVERSE_READ_EN to also exercise reverse reads.
module tb_aes_key_schedule_iter;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         ready, done, valid, err;
  logic [3:0]   rd_idx;
  logic         rd_rev;
  logic [127:0] rd_data;

  logic         m_start;
  logic [1:0]   m_key_len;
  logic         m_ready, m_done, m_valid, m_err;
  logic [127:0] m_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_key_schedule_iter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .key_len (key_len),
    .key     (key),
    .ready   (ready),
    .done    (done),
    .valid   (valid),
    .err     (err),
    .rd_idx  (rd_idx),
`ifdef AES_KS_REVERSE_READ_EN
    .rd_rev  (rd_rev),
`endif
    .rd_data (rd_data)
  );

  aes_key_schedule_iter #(.MAX_KEY_BITS(128)) dut128 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (m_start),
    .key_len (m_key_len),
    .key     (key),
    .ready   (m_ready),
    .done    (m_done),
    .valid   (m_valid),
    .err     (m_err),
    .rd_idx  (rd_idx),
`ifdef AES_KS_REVERSE_READ_EN
    .rd_rev  (rd_rev),
`endif
    .rd_data (m_rd_data)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] idx,
                    input logic [127:0] exp);
    rd_idx = idx;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic run(input logic [1:0] kl, input logic [255:0] k,
                     input int exp_n, input bit poke);
    int cyc;
    key_len = kl;
    key     = k;
    start   = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    check("valid_low_c1", 128'(valid), 128'd0);
    check("ready_low_c1", 128'(ready), 128'd0);
    while (!done && cyc < 200) begin
      if (poke && cyc == 10) begin
        start   = 1'b1;
        key_len = 2'd3;
      end
      tick();
      cyc++;
      if (poke && cyc == 11) begin
        start   = 1'b0;
        key_len = kl;
        check("busy_start_no_err", 128'(err), 128'd0);
      end
    end
    check("done_cycle", 128'(cyc), 128'(exp_n));
    check("done_valid", 128'(valid), 128'd1);
    check("done_ready", 128'(ready), 128'd0);
    tick();
    check("idle_ready", 128'(ready), 128'd1);
    check("done_pulse", 128'(done), 128'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    key_len   = 2'd0;
    key       = '0;
    rd_idx    = 4'd0;
    rd_rev    = 1'b0;
    m_start   = 1'b0;
    m_key_len = 2'd0;
    repeat (3) tick();
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_valid", 128'(valid), 128'd0);
    check("rst_done",  128'(done),  128'd0);
    check("rst_err",   128'(err),   128'd0);
    check("rst_rd",    rd_data,     128'd0);
    reset_n = 1'b1;
    tick();

    run(2'd0, K128, 41, 1'b0);
    rd("a128_r0",  4'd0,  K128[255:128]);
    rd("a128_r1",  4'd1,  R128_1);
    rd("a128_r10", 4'd10, R128_10);
    rd("a128_r11", 4'd11, 128'h0);
`ifdef AES_KS_REVERSE_READ_EN
    rd_rev = 1'b1;
    rd("rev_r0",  4'd0,  R128_10);
    rd("rev_r10", 4'd10, K128[255:128]);
    rd("rev_r11", 4'd11, 128'h0);
    rd_rev = 1'b0;
`endif

    key_len = 2'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("rsv_err",   128'(err),   128'd1);
    check("rsv_ready", 128'(ready), 128'd1);
    check("rsv_valid", 128'(valid), 128'd1);
    tick();
    check("rsv_err_pulse", 128'(err), 128'd0);
    rd("rsv_keep_r10", 4'd10, R128_10);

    m_key_len = 2'd2;
    m_start   = 1'b1;
    tick();
    check("max128_err", 128'(m_err), 128'd1);
    check("max128_rdy", 128'(m_ready), 128'd1);
    m_key_len = 2'd0;
    tick();
    m_start = 1'b0;
    check("max128_ok_no_err", 128'(m_err), 128'd0);
    check("max128_ok_busy", 128'(m_ready), 128'd0);

    run(2'd1, K192, 47, 1'b0);
    rd("a192_r0",  4'd0,  K192[255:128]);
    rd("a192_r12", 4'd12, R192_12);
    rd("a192_r13", 4'd13, 128'h0);

    run(2'd2, K256, 53, 1'b0);
    rd("a256_r1",  4'd1,  K256[127:0]);
    rd("a256_r14", 4'd14, R256_14);
    rd("a256_r15", 4'd15, 128'h0);

    rd_idx  = 4'd1;
    key_len = 2'd0;
    key     = K128;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_valid", 128'(valid), 128'd0);
    check("abort_ready", 128'(ready), 128'd1);
    check("abort_rd",    rd_data,     128'd0);
    check("abort_done",  128'(done),  128'd0);

    run(2'd0, K128, 41, 1'b1);
    rd("rerun_r10", 4'd10, R128_10);
    rd("rerun_r0",  4'd0,  K128[255:128]);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
